// File: rtl/mem_io_responder_if.sv
// Request/ready bus between the datapath's MAR/MDR and the memory responder.
// The master drives the request side, and the slave returns read data, ready and error.
interface mem_io_responder_if;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [15:0] MDR_In;
  logic        R;
  logic        ERR;

  modport master (
    output MAR, MDR, MEM_REQ, MEM_WE,
    input  MDR_In, R, ERR
  );

  modport slave (
    input  MAR, MDR, MEM_REQ, MEM_WE,
    output MDR_In, R, ERR
  );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: an on-chip word RAM with programmable wait states and a memory-mapped
// switch/hex I/O port, served over a four-phase request/ready handshake.
module mem_io_responder #(
  parameter int          DEPTH_LOG2  = 8,
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic                Clk,
  input  logic                Reset,
  mem_io_responder_if.slave   bus,
  input  logic [9:0]          SW,
  output logic [15:0]         HEX_OUT
);

  localparam int         RAM_WORDS = 2 ** DEPTH_LOG2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        we_q, we_d;
  logic        r_q, r_d;
  logic        err_q, err_d;
  logic [15:0] mdr_in_q, mdr_in_d;
  logic [15:0] hex_q, hex_d;

  logic [15:0] mem_q [RAM_WORDS];

  logic                  do_access;
  logic [15:0]           acc_addr;
  logic [15:0]           acc_data;
  logic                  acc_we;
  logic                  acc_in_range;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  ram_we;

  // A zero-wait build performs the access on the capture edge, so it must use the live bus values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = we_q;
    do_access = 1'b0;
    acc_addr  = addr_q;
    acc_data  = data_q;
    acc_we    = we_q;

    case (state_q)
      S_IDLE: begin
        if (bus.MEM_REQ) begin
          addr_d = bus.MAR;
          data_d = bus.MDR;
          we_d   = bus.MEM_WE;
          cnt_d  = WAIT_LOAD;
          if (WAIT_STATES == 0) begin
            acc_addr  = bus.MAR;
            acc_data  = bus.MDR;
            acc_we    = bus.MEM_WE;
            do_access = 1'b1;
            state_d   = S_ACK;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        if (!bus.MEM_REQ) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ram_idx      = acc_addr[DEPTH_LOG2-1:0];
  assign acc_in_range = (acc_addr[15:DEPTH_LOG2] == '0);

  // The I/O address takes priority over the RAM and out-of-range decode.
  always_comb begin
    r_d      = r_q;
    err_d    = err_q;
    mdr_in_d = mdr_in_q;
    hex_d    = hex_q;
    ram_we   = 1'b0;

    if (state_q == S_ACK && !bus.MEM_REQ) begin
      r_d   = 1'b0;
      err_d = 1'b0;
    end

    if (do_access) begin
      r_d   = 1'b1;
      err_d = 1'b0;
      if (acc_addr == IO_ADDR) begin
        if (acc_we) begin
          hex_d = acc_data;
        end else begin
          mdr_in_d = {6'b0, SW};
        end
      end else if (acc_in_range) begin
        if (acc_we) begin
          ram_we = 1'b1;
        end else begin
          mdr_in_d = mem_q[ram_idx];
        end
      end else begin
        err_d = 1'b1;
        if (!acc_we) begin
          mdr_in_d = 16'h0000;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 16'h0000;
      data_q   <= 16'h0000;
      we_q     <= 1'b0;
      r_q      <= 1'b0;
      err_q    <= 1'b0;
      mdr_in_q <= 16'h0000;
      hex_q    <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      r_q      <= r_d;
      err_q    <= err_d;
      mdr_in_q <= mdr_in_d;
      hex_q    <= hex_d;
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge Clk) begin
    if (ram_we) begin
      mem_q[ram_idx] <= acc_data;
    end
  end

  assign bus.R      = r_q;
  assign bus.ERR    = err_q;
  assign bus.MDR_In = mdr_in_q;
  assign HEX_OUT    = hex_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: a 2-wait-state instance checked every cycle against a transaction-level
// model, plus a zero-wait instance checked with directed expectations.
module tb_mem_io_responder;

  localparam int WS_A = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  sw = 10'h000;
  logic [15:0] hex_a;
  logic [15:0] hex_b;

  int n_compared = 0;
  int n_failed = 0;

  mem_io_responder_if bus_a ();
  mem_io_responder_if bus_b ();

  mem_io_responder #(.DEPTH_LOG2(8), .WAIT_STATES(WS_A), .IO_ADDR(16'hFFFF)) dut_a (
    .Clk(clk), .Reset(rst_n), .bus(bus_a), .SW(sw), .HEX_OUT(hex_a)
  );

  mem_io_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0), .IO_ADDR(16'hFFFF)) dut_b (
    .Clk(clk), .Reset(rst_n), .bus(bus_b), .SW(sw), .HEX_OUT(hex_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model of instance A: a request captured on edge N completes on edge N+WS+1.
  int          edge_no = 0;
  int          acc_edge = 0;
  bit          m_busy = 1'b0;
  bit          m_ready = 1'b0;
  logic [15:0] m_addr;
  logic [15:0] m_data;
  logic        m_we;
  logic [15:0] m_ram [256];
  logic        exp_r = 1'b0;
  logic        exp_err = 1'b0;
  logic [15:0] exp_mdr = 16'h0000;
  logic [15:0] exp_hex = 16'h0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_ready = 1'b0;
      exp_r   = 1'b0;
      exp_err = 1'b0;
      exp_mdr = 16'h0000;
      exp_hex = 16'h0000;
    end else begin
      edge_no++;
      if (m_ready) begin
        if (!bus_a.MEM_REQ) begin
          m_ready = 1'b0;
          exp_r   = 1'b0;
          exp_err = 1'b0;
        end
      end else if (m_busy) begin
        if (edge_no == acc_edge) begin
          m_busy  = 1'b0;
          m_ready = 1'b1;
          exp_r   = 1'b1;
          if (m_addr == 16'hFFFF) begin
            if (m_we) exp_hex = m_data;
            else exp_mdr = {6'b0, sw};
          end else if (m_addr < 16'd256) begin
            if (m_we) m_ram[m_addr[7:0]] = m_data;
            else exp_mdr = m_ram[m_addr[7:0]];
          end else begin
            exp_err = 1'b1;
            if (!m_we) exp_mdr = 16'h0000;
          end
        end
      end else if (bus_a.MEM_REQ) begin
        m_addr   = bus_a.MAR;
        m_data   = bus_a.MDR;
        m_we     = bus_a.MEM_WE;
        m_busy   = 1'b1;
        acc_edge = edge_no + WS_A + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("a_R", {15'b0, bus_a.R}, {15'b0, exp_r});
      checkOutput("a_ERR", {15'b0, bus_a.ERR}, {15'b0, exp_err});
      checkOutput("a_MDR_In", bus_a.MDR_In, exp_mdr);
      checkOutput("a_HEX_OUT", hex_a, exp_hex);
    end
  end

  function automatic logic get_r(input int sel);
    return (sel == 0) ? bus_a.R : bus_b.R;
  endfunction

  function automatic logic get_err(input int sel);
    return (sel == 0) ? bus_a.ERR : bus_b.ERR;
  endfunction

  function automatic logic [15:0] get_mdr(input int sel);
    return (sel == 0) ? bus_a.MDR_In : bus_b.MDR_In;
  endfunction

  task automatic drive_bus(input int sel, input logic [15:0] addr, input logic [15:0] data,
                           input logic we, input logic req);
    if (sel == 0) begin
      bus_a.MAR = addr; bus_a.MDR = data; bus_a.MEM_WE = we; bus_a.MEM_REQ = req;
    end else begin
      bus_b.MAR = addr; bus_b.MDR = data; bus_b.MEM_WE = we; bus_b.MEM_REQ = req;
    end
  endtask

  // One full four-phase transaction; while held in ACK the request fields are scrambled.
  task automatic applyStimulus(input int sel, input logic [15:0] addr, input logic [15:0] data,
                               input logic we, input int hold, output int latency,
                               output logic [15:0] rd, output logic rd_err);
    int guard;
    @(negedge clk);
    drive_bus(sel, addr, data, we, 1'b1);
    latency = 0;
    do begin
      @(negedge clk);
      latency++;
    end while (!get_r(sel) && latency < 40);
    checkOutput("r_rise", {15'b0, get_r(sel)}, 16'd1);
    rd = get_mdr(sel);
    rd_err = get_err(sel);
    for (int i = 0; i < hold; i++) begin
      drive_bus(sel, ~addr, data ^ 16'h5A5A, ~we, 1'b1);
      @(negedge clk);
      checkOutput("r_held", {15'b0, get_r(sel)}, 16'd1);
    end
    drive_bus(sel, addr, data, we, 1'b0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (get_r(sel) && guard < 40);
    checkOutput("r_fall_cycles", 16'(guard), 16'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    logic [15:0] rd;
    logic        rd_err;

    drive_bus(0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    drive_bus(1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_R", {15'b0, bus_a.R}, 16'd0);
    checkOutput("rst_ERR", {15'b0, bus_a.ERR}, 16'd0);
    checkOutput("rst_MDR_In", bus_a.MDR_In, 16'h0000);
    checkOutput("rst_HEX_OUT", hex_a, 16'h0000);

    $display("[TB] basic write/read");
    applyStimulus(0, 16'h0012, 16'hBEEF, 1'b1, 0, lat, rd, rd_err);
    applyStimulus(0, 16'h0012, 16'h0000, 1'b0, 0, lat, rd, rd_err);
    checkOutput("read_latency", 16'(lat), 16'(WS_A + 2));
    checkOutput("read_0012", rd, 16'hBEEF);
    checkOutput("read_0012_err", {15'b0, rd_err}, 16'd0);

    $display("[TB] held request");
    applyStimulus(0, 16'h0005, 16'h0001, 1'b1, 10, lat, rd, rd_err);
    applyStimulus(0, 16'h0005, 16'h0000, 1'b0, 0, lat, rd, rd_err);
    checkOutput("read_0005", rd, 16'h0001);

    $display("[TB] I/O port");
    sw = 10'h2A5;
    applyStimulus(0, 16'hFFFF, 16'h0000, 1'b0, 0, lat, rd, rd_err);
    checkOutput("read_sw", rd, 16'h02A5);
    applyStimulus(0, 16'hFFFF, 16'h1234, 1'b1, 0, lat, rd, rd_err);
    checkOutput("hex_write", hex_a, 16'h1234);
    checkOutput("mdr_after_io_write", bus_a.MDR_In, 16'h02A5);

    $display("[TB] out of range");
    applyStimulus(0, 16'h0000, 16'hC0DE, 1'b1, 0, lat, rd, rd_err);
    applyStimulus(0, 16'h0100, 16'h0000, 1'b0, 0, lat, rd, rd_err);
    checkOutput("oor_read_data", rd, 16'h0000);
    checkOutput("oor_read_err", {15'b0, rd_err}, 16'd1);
    applyStimulus(0, 16'h8000, 16'h9999, 1'b1, 0, lat, rd, rd_err);
    checkOutput("oor_write_err", {15'b0, rd_err}, 16'd1);
    applyStimulus(0, 16'h0000, 16'h0000, 1'b0, 0, lat, rd, rd_err);
    checkOutput("ram0_intact", rd, 16'hC0DE);

    $display("[TB] reset during wait");
    applyStimulus(0, 16'h0003, 16'h5555, 1'b1, 0, lat, rd, rd_err);
    @(negedge clk);
    drive_bus(0, 16'h0003, 16'hAAAA, 1'b1, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    drive_bus(0, 16'h0003, 16'hAAAA, 1'b1, 1'b0);
    #1;
    checkOutput("midrst_R", {15'b0, bus_a.R}, 16'd0);
    checkOutput("midrst_ERR", {15'b0, bus_a.ERR}, 16'd0);
    checkOutput("midrst_MDR_In", bus_a.MDR_In, 16'h0000);
    checkOutput("midrst_HEX_OUT", hex_a, 16'h0000);
    @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(0, 16'h0003, 16'h0000, 1'b0, 0, lat, rd, rd_err);
    checkOutput("read_0003_after_rst", rd, 16'h5555);

    $display("[TB] zero wait states");
    applyStimulus(1, 16'h0010, 16'h7777, 1'b1, 0, lat, rd, rd_err);
    checkOutput("b_write_latency", 16'(lat), 16'd1);
    applyStimulus(1, 16'h0010, 16'h0000, 1'b0, 3, lat, rd, rd_err);
    checkOutput("b_read_latency", 16'(lat), 16'd1);
    checkOutput("b_read_0010", rd, 16'h7777);
    checkOutput("b_read_err", {15'b0, rd_err}, 16'd0);
    checkOutput("b_mdr_after_mar_change", bus_b.MDR_In, 16'h7777);
    checkOutput("b_err_after_mar_change", {15'b0, bus_b.ERR}, 16'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
